// File: rtl/updown_key_ctrl.sv
// Push-button front end for the up/down load counter. It synchronises and
// debounces three raw keys, then turns them into one-cycle inc/dec/load
// pulses. Holding up or down auto-repeats the pulse.
module updown_key_ctrl #(
  parameter int DEBOUNCE      = 4,
  parameter int REPEAT_DELAY  = 20,
  parameter int REPEAT_PERIOD = 8,
  parameter int TW            = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_up,
  input  logic key_dn,
  input  logic key_ld,
  output logic inc,
  output logic dec,
  output logic load,
  output logic held
);

  localparam logic [TW-1:0] DB_LAST  = TW'(DEBOUNCE - 1);
  localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);

  // Key index: 0 = up, 1 = down, 2 = load
  logic [2:0] keys_raw;
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] lvl;
  logic [2:0] lvl_prev_q;
  logic [2:0] rise;

  assign keys_raw = {key_ld, key_dn, key_up};

  // Two-stage synchronisers and the delayed debounced level used for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_prev_q <= '0;
    end else begin
      sync1_q    <= keys_raw;
      sync2_q    <= sync1_q;
      lvl_prev_q <= lvl;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_key
      logic [TW-1:0] cnt_q;
      logic [TW-1:0] cnt_d;
      logic          lvl_q;
      logic          lvl_d;

      // The level flips only after DEBOUNCE consecutive cycles of disagreement
      always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        if (sync2_q[gi] != lvl_q) begin
          if (cnt_q == DB_LAST) begin
            lvl_d = ~lvl_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      // Debounce counter and debounced level registers
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
          lvl_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          lvl_q <= lvl_d;
        end
      end

      assign lvl[gi] = lvl_q;
    end
  endgenerate

  assign rise = lvl & ~lvl_prev_q;

  typedef enum logic [1:0] {IDLE, WAIT, RPT, LOCK} state_t;

  state_t        state_q, state_d;
  logic          dir_q, dir_d;          // latched direction: 1 = down
  logic [TW-1:0] tmr_q, tmr_d;
  logic          pulse_inc, pulse_dec;
  logic          own_lvl, opp_rise;

  assign own_lvl  = dir_q ? lvl[1]  : lvl[0];
  assign opp_rise = dir_q ? rise[0] : rise[1];

  // Next-state logic: first pulse, repeat timing, release and lock-out
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    tmr_d     = tmr_q;
    pulse_inc = 1'b0;
    pulse_dec = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (lvl[0] && lvl[1]) begin
          state_d = LOCK;
        end else if (rise[0]) begin
          pulse_inc = 1'b1;
          dir_d     = 1'b0;
          state_d   = WAIT;
        end else if (rise[1]) begin
          pulse_dec = 1'b1;
          dir_d     = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT, RPT: begin
        // The opposite key wins over a simultaneous release, so it is never taken as a new press
        if (opp_rise) begin
          state_d = LOCK;
          tmr_d   = '0;
        end else if (!own_lvl) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else if (tmr_q == ((state_q == WAIT) ? DLY_LAST : PER_LAST)) begin
          pulse_inc = ~dir_q;
          pulse_dec = dir_q;
          tmr_d     = '0;
          state_d   = RPT;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      LOCK: begin
        tmr_d = '0;
        if (!lvl[0] && !lvl[1]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  logic inc_q, dec_q, load_q, held_q;

  // State register and registered outputs; a load pulse swallows a coincident inc/dec
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      tmr_q   <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      load_q  <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      tmr_q   <= tmr_d;
      inc_q   <= pulse_inc & ~rise[2];
      dec_q   <= pulse_dec & ~rise[2];
      load_q  <= rise[2];
      held_q  <= (state_d == WAIT) || (state_d == RPT);
    end
  end

  assign inc  = inc_q;
  assign dec  = dec_q;
  assign load = load_q;
  assign held = held_q;

endmodule

// File: tb/tb_updown_key_ctrl.sv
// Directed bench for updown_key_ctrl with default parameters
// (DEBOUNCE=4, REPEAT_DELAY=20, REPEAT_PERIOD=8).
module tb_updown_key_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_up = 1'b0;
  logic key_dn = 1'b0;
  logic key_ld = 1'b0;
  logic inc, dec, load, held;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int inc_t[$];
  int dec_t[$];
  int ld_t[$];
  int cnt_vals[$];
  int n_inc = 0, n_dec = 0, n_ld = 0;
  logic prev_ud = 1'b0;
  logic [7:0] cnt_q = 8'd0;
  logic [7:0] cnt_last = 8'd0;

  always #5 clk = ~clk;

  updown_key_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .key_up(key_up),
    .key_dn(key_dn),
    .key_ld(key_ld),
    .inc   (inc),
    .dec   (dec),
    .load  (load),
    .held  (held)
  );

  // 8-bit up/down load counter driven by the controller, load value 254
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else if (load) cnt_q <= 8'd254;
    else if (inc) cnt_q <= cnt_q + 8'd1;
    else if (dec) cnt_q <= cnt_q - 8'd1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_q(input string name, input int act[$], input int exp[$]);
    chk({name, "_count"}, act.size(), exp.size());
    for (int i = 0; i < exp.size() && i < act.size(); i++)
      chk($sformatf("%s[%0d]", name, i), act[i], exp[i]);
  endtask

  // Monitor: cyc is the index of the rising edge that produced the sampled outputs
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (inc) begin n_inc++; inc_t.push_back(cyc); end
      if (dec) begin n_dec++; dec_t.push_back(cyc); end
      if (load) begin n_ld++; ld_t.push_back(cyc); end
      if (cnt_q != cnt_last) cnt_vals.push_back(int'(cnt_q));
      cnt_last = cnt_q;
      if (inc || dec || load) begin
        checks++;
        if ((int'(inc) + int'(dec) + int'(load)) > 1 || ((inc || dec) && prev_ud)) begin
          failures++;
          $display("FAIL pulse_rules at cycle %0d: inc=%0b dec=%0b load=%0b prev_incdec=%0b required one-hot, spaced",
                   cyc, inc, dec, load, prev_ud);
        end
      end
      prev_ud = inc | dec;
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic clear_logs();
    inc_t.delete();
    dec_t.delete();
    ld_t.delete();
  endtask

  typedef struct {
    logic up, dn, ld;
    int   n;
    int   e_inc, e_dec, e_ld;
    logic e_held;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int e0, e1, t;
    int exp_q[$];
    int s_inc, s_dec, s_ld;

    tbl[0]  = '{0, 0, 0, 10, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0,  3, 0, 0, 0, 0};  // 3-cycle glitch rejected
    tbl[2]  = '{0, 0, 0, 10, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0,  4, 0, 0, 0, 0};  // 4-cycle press accepted
    tbl[4]  = '{0, 0, 0, 12, 0, 1, 0, 0};
    tbl[5]  = '{0, 0, 1,  6, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 10, 0, 0, 1, 0};
    tbl[7]  = '{1, 0, 0, 30, 2, 0, 0, 1};
    tbl[8]  = '{0, 0, 0, 15, 1, 0, 0, 0};
    tbl[9]  = '{1, 1, 0, 20, 0, 0, 0, 0};  // simultaneous press locks out
    tbl[10] = '{0, 0, 0, 15, 0, 0, 0, 0};
    tbl[11] = '{0, 1, 0, 12, 0, 1, 0, 1};
    tbl[12] = '{0, 0, 0, 20, 0, 0, 0, 0};

    // Reset with key_up held, then release and follow the auto-repeat train
    key_up = 1'b1;
    rst_n  = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_inc", int'(inc), 0);
    chk("rst_dec", int'(dec), 0);
    chk("rst_load", int'(load), 0);
    chk("rst_held", int'(held), 0);
    rst_n = 1'b1;
    e0 = cyc + 1;
    clear_logs();
    wait_until(e0 + 10);
    exp_q = '{e0 + 6};
    chk_q("rst_first_inc", inc_t, exp_q);
    chk("rst_held_after", int'(held), 1);
    t = e0 + 6;
    wait_until(t + 53);
    key_up = 1'b0;
    wait_until(t + 80);
    exp_q = '{t, t + 20, t + 28, t + 36, t + 44, t + 52};
    chk_q("repeat_inc", inc_t, exp_q);
    chk("repeat_held_end", int'(held), 0);

    // Table-driven steps: pulse counts within each step and held at its end
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      key_up = tbl[i].up;
      key_dn = tbl[i].dn;
      key_ld = tbl[i].ld;
      s_inc = n_inc; s_dec = n_dec; s_ld = n_ld;
      repeat (tbl[i].n - 1) @(negedge clk);
      chk($sformatf("vec%0d_inc", i), n_inc - s_inc, tbl[i].e_inc);
      chk($sformatf("vec%0d_dec", i), n_dec - s_dec, tbl[i].e_dec);
      chk($sformatf("vec%0d_load", i), n_ld - s_ld, int'(tbl[i].e_ld));
      chk($sformatf("vec%0d_held", i), int'(held), int'(tbl[i].e_held));
    end

    // Load lands on the same cycle as the second repeat: inc dropped, timer unaffected
    repeat (10) @(negedge clk);
    clear_logs();
    key_up = 1'b1;
    e0 = cyc + 1;
    t = e0 + 6;
    wait_until(t + 21);
    key_ld = 1'b1;
    wait_until(t + 31);
    key_ld = 1'b0;
    wait_until(t + 37);
    key_up = 1'b0;
    wait_until(t + 60);
    exp_q = '{t, t + 20, t + 36};
    chk_q("prio_inc", inc_t, exp_q);
    exp_q = '{t + 28};
    chk_q("prio_load", ld_t, exp_q);

    // Opposing keys lock out until both are released
    repeat (10) @(negedge clk);
    clear_logs();
    key_up = 1'b1;
    e0 = cyc + 1;
    wait_until(e0 + 15);
    key_dn = 1'b1;
    wait_until(e0 + 45);
    chk("lock_held", int'(held), 0);
    key_up = 1'b0;
    wait_until(e0 + 75);
    chk("lock_inc_count", inc_t.size(), 1);
    chk("lock_dec_count", dec_t.size(), 0);
    key_dn = 1'b0;
    wait_until(e0 + 95);
    key_dn = 1'b1;
    e1 = cyc + 1;
    wait_until(e1 + 14);
    key_dn = 1'b0;
    wait_until(e1 + 40);
    exp_q = '{e1 + 6};
    chk_q("unlock_dec", dec_t, exp_q);
    chk("unlock_inc_count", inc_t.size(), 1);

    // Asynchronous reset in the middle of an auto-repeat pulse
    repeat (10) @(negedge clk);
    clear_logs();
    key_up = 1'b1;
    e0 = cyc + 1;
    wait_until(e0 + 33);
    @(posedge clk);
    #2;
    chk("midrst_pre_inc", int'(inc), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_inc", int'(inc), 0);
    chk("midrst_held", int'(held), 0);
    repeat (3) @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
    e1 = cyc + 1;
    wait_until(e1 + 12);
    key_up = 1'b0;
    wait_until(e1 + 40);
    exp_q = '{e1 + 6};
    chk_q("midrst_repress", inc_t, exp_q);

    // Counter integration: preset 254, then three incs wrap through 0
    cnt_vals.delete();
    key_ld = 1'b1;
    e0 = cyc + 1;
    wait_until(e0 + 10);
    key_ld = 1'b0;
    wait_until(e0 + 25);
    chk("cnt_preset", int'(cnt_q), 254);
    key_up = 1'b1;
    e1 = cyc + 1;
    t = e1 + 6;
    wait_until(t + 29);
    key_up = 1'b0;
    wait_until(t + 50);
    exp_q = '{254, 255, 0, 1};
    chk_q("cnt_seq", cnt_vals, exp_q);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/updown_key_ctrl.md
Name: updown_key_ctrl

Overview:
- Front-end controller for the 8-bit up/down load counter.
- Takes three raw, asynchronous push-button levels (up, down, load), synchronises and debounces them, and turns them into single-cycle inc/dec/load pulses with hold-to-auto-repeat.
- Its inc, dec and load outputs connect directly to the counter's inc, dec and load inputs, on the same clk/rst_n.

Parameters:
- DEBOUNCE, 4, consecutive cycles a synchronised key must differ from its debounced level before the level flips (>=1).
- REPEAT_DELAY, 20, cycles from the first pulse to the first auto-repeat pulse while the key is held (>=2).
- REPEAT_PERIOD, 8, cycles between subsequent auto-repeat pulses (>=2).
- TW, 16, width of the debounce and repeat timers; every cycle-count parameter must be < 2^TW.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_up  input  1  raw up button, active-high, asynchronous to clk.
- key_dn  input  1  raw down button, active-high, asynchronous to clk.
- key_ld  input  1  raw load button, active-high, asynchronous to clk.
- inc  output  1  registered one-cycle increment pulse to the counter.
- dec  output  1  registered one-cycle decrement pulse to the counter.
- load  output  1  registered one-cycle load pulse to the counter.
- held  output  1  registered; high while the FSM is in WAIT or RPT.

Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.

Behaviour:
- Reset (rst_n=0, takes effect immediately):
  - inc, dec, load, held = 0.
  - Synchronisers, debounced levels and timers = 0; FSM = IDLE.
- Synchroniser: two flip-flops per key. The debouncer uses only the second stage.
- Debounce, per key:
  - Counter increments each cycle that the synchronised value differs from the debounced level; it clears on any cycle they match.
  - When the counter reaches DEBOUNCE, the debounced level flips and the counter clears.
  - Glitches shorter than DEBOUNCE cycles never change the level.
- Press latency: raw key stable high before edge E0 → the debounced level rises at edge E0+1+DEBOUNCE.
- Edge detection: a rising edge is registered debounced level 0→1.
- Load path:
  - A debounced key_ld rising edge gives load=1 for exactly one cycle, starting at edge E0+2+DEBOUNCE.
  - No auto-repeat on load.
- Up/down FSM: states IDLE, WAIT, RPT, LOCK.
  - IDLE, up rising edge with dn level 0: inc pulse; repeat timer := 0; go WAIT. Down is symmetric and gives a dec pulse. The direction is latched for the press.
  - IDLE, both levels 1 (including simultaneous rises): go LOCK, no pulse.
  - WAIT: timer counts each cycle. When the timer reaches REPEAT_DELAY-1: pulse in the latched direction; timer := 0; go RPT.
  - RPT: when the timer reaches REPEAT_PERIOD-1: pulse; timer := 0.
  - WAIT/RPT: latched key level falls → go IDLE, no pulse, timer cleared.
  - WAIT/RPT: opposite key level rises → go LOCK, no pulse that cycle.
  - LOCK: no pulses; return to IDLE only when both up and dn levels are 0.
- Pulse spacing while held: first pulse at cycle T; repeats at T+REPEAT_DELAY, then every REPEAT_PERIOD cycles.
- Output rules:
  - At most one of inc, dec, load is 1 in any cycle.
  - Load has priority: if a load pulse and an inc/dec pulse fall in the same cycle, the inc/dec pulse is dropped (not deferred). The repeat timer continues unaffected.
  - inc and dec are never high in consecutive cycles.
- Reset mid-operation: every output drops immediately. A key still held when rst_n releases is a fresh press; it pulses again after the full press latency.

Test Plan:
- Reset with keys held: rst_n=0, key_up=1 → inc/dec/load=0. Release rst_n at edge E0 → exactly one inc at edge E0+2+DEBOUNCE (6 with defaults), then held=1.
- Glitch rejection: key_dn high for 3 cycles (DEBOUNCE=4) → no dec, held stays 0. Key_dn high for 4+ cycles → one dec.
- Auto-repeat: hold key_up for 60 cycles after its first inc at T → inc at T, T+20, T+28, T+36, T+44, T+52 while held. Release → no further inc; FSM in IDLE.
- Load priority: hold key_up, then press key_ld so that load lands on cycle T+28 → load=1 and inc=0 at T+28; next inc at T+36.
- Opposing keys: key_up held (in WAIT), press key_dn → no further inc/dec. Release only key_up → still none. Release key_dn, then press key_dn → dec after normal latency.
- Integration with counter #(8): preset load d=254, then hold key_up long enough for 3 inc pulses → counter q goes 254, 255, 0, 1 (wrap-around).
